// File: rtl/cpu_pkg.sv
// Shared types and defaults for the ExceptioNull CPU stage sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_HALT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_REGRD  = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_WBRES  = 4'd6,
        S_WB     = 4'd7,
        S_PCUPD  = 4'd8
    } seq_state_t;

    localparam int MEM_TIMEOUT_DEF = 8;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/seq_wait_timer.sv
// Counts MEM-state cycles spent waiting on mem_ready and flags the last allowed one.
module seq_wait_timer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic mem_ready,
    output logic timeout
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (!mem_ready)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Timeout fires on the final tolerated wait cycle; mem_ready still wins in the FSM.
    assign timeout = (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle stage sequencer with run/halt/step control and memory timeout.
// Optional performance counters enabled by defining CPU_SEQ_PERF_CNT_EN.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             reg_w_en,
    input  logic             mem_ready,
    output logic             fetch,
    output logic             decode,
    output logic             reg_read,
    output logic             execute,
    output logic             access_mem,
    output logic             wb_resolve,
    output logic             writeback,
    output logic             update_pc,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stall_cycles
);

    seq_state_t state_q, state_d;
    logic       sstep_q, sstep_d;
    logic       err_q, err_d;
    logic [7:0] stb_q, stb_d;
    logic       halted_q;
    logic       timeout;

    seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q != S_MEM),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_comb begin
        state_d = state_q;
        sstep_d = sstep_q;
        err_d   = err_q;
        case (state_q)
            S_HALT: begin
                if (!err_q) begin
                    if (run) begin
                        state_d = S_FETCH;
                        sstep_d = 1'b0;
                    end else if (step) begin
                        state_d = S_FETCH;
                        sstep_d = 1'b1;
                    end
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_REGRD;
            S_REGRD:  state_d = S_EXEC;
            S_EXEC: begin
                if (mem_r_en && mem_w_en) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if (mem_r_en || mem_w_en)
                    state_d = S_MEM;
                else if (reg_w_en)
                    state_d = S_WBRES;
                else
                    state_d = S_PCUPD;
            end
            S_MEM: begin
                if (mem_ready)
                    state_d = reg_w_en ? S_WBRES : S_PCUPD;
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WBRES:  state_d = S_WB;
            S_WB:     state_d = S_PCUPD;
            S_PCUPD: begin
                sstep_d = 1'b0;
                state_d = (halt_req || !run || sstep_q) ? S_HALT : S_FETCH;
            end
            default:  state_d = S_HALT;
        endcase
        // Strobes are registered from the next state so each lines up with its state.
        stb_d = (state_d == S_HALT) ? 8'd0 : (8'd1 << (state_d - 4'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HALT;
            sstep_q  <= 1'b0;
            err_q    <= 1'b0;
            stb_q    <= '0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sstep_q  <= sstep_d;
            err_q    <= err_d;
            stb_q    <= stb_d;
            halted_q <= (state_d == S_HALT);
        end
    end

    assign fetch      = stb_q[0];
    assign decode     = stb_q[1];
    assign reg_read   = stb_q[2];
    assign execute    = stb_q[3];
    assign access_mem = stb_q[4];
    assign wb_resolve = stb_q[5];
    assign writeback  = stb_q[6];
    assign update_pc  = stb_q[7];
    assign halted     = halted_q;
    assign err        = err_q;

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] ret_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_q   <= '0;
            stall_q <= '0;
        end else begin
            if (state_q == S_PCUPD)
                ret_q <= ret_q + CNT_W'(1);
            if (state_q == S_MEM && !mem_ready)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign retired      = ret_q;
    assign stall_cycles = stall_q;
`else
    assign retired      = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: two sequencers (timeout 8 and 4) against an instruction-plan model.
module tb_cpu_sequencer;

    localparam int H = 0, F = 1, D = 2, R = 3, E = 4, M = 5, WR = 6, W = 7, P = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic run = 1'b0, step = 1'b0, halt_req = 1'b0;
    logic mem_r_en = 1'b0, mem_w_en = 1'b0, reg_w_en = 1'b0, mem_ready = 1'b1;

    logic [1:0][7:0]  stb;
    logic [1:0]       hlt, er;
    logic [1:0][15:0] ret, stl;

    int checks = 0;
    int errs   = 0;

    // Model state: current stage, remaining planned stages of the instruction.
    int          cur [2];
    int          pl  [2][4];
    int          pn  [2];
    int          pi  [2];
    int          waits [2];
    bit          ss  [2];
    bit          merr [2];
    int unsigned mret [2];
    int unsigned mstl [2];

    always #5 clk = ~clk;

    cpu_sequencer #(.MEM_TIMEOUT(8), .CNT_W(16)) u_d8 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .reg_w_en(reg_w_en), .mem_ready(mem_ready),
        .fetch(stb[0][0]), .decode(stb[0][1]), .reg_read(stb[0][2]), .execute(stb[0][3]),
        .access_mem(stb[0][4]), .wb_resolve(stb[0][5]), .writeback(stb[0][6]),
        .update_pc(stb[0][7]), .halted(hlt[0]), .err(er[0]),
        .retired(ret[0]), .stall_cycles(stl[0])
    );

    cpu_sequencer #(.MEM_TIMEOUT(4), .CNT_W(16)) u_d4 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .reg_w_en(reg_w_en), .mem_ready(mem_ready),
        .fetch(stb[1][0]), .decode(stb[1][1]), .reg_read(stb[1][2]), .execute(stb[1][3]),
        .access_mem(stb[1][4]), .wb_resolve(stb[1][5]), .writeback(stb[1][6]),
        .update_pc(stb[1][7]), .halted(hlt[1]), .err(er[1]),
        .retired(ret[1]), .stall_cycles(stl[1])
    );

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            cur[k] = H; pn[k] = 0; pi[k] = 0; waits[k] = 0;
            ss[k] = 1'b0; merr[k] = 1'b0; mret[k] = 0; mstl[k] = 0;
        end
    endfunction

    function automatic int next_stage(int k);
        int s;
        s = pl[k][pi[k]];
        pi[k] = pi[k] + 1;
        return s;
    endfunction

    function automatic void m_step();
        for (int k = 0; k < 2; k++) begin
            int tmo;
            tmo = (k == 0) ? 8 : 4;
            case (cur[k])
                H: if (!merr[k]) begin
                    if (run)       begin cur[k] = F; ss[k] = 1'b0; end
                    else if (step) begin cur[k] = F; ss[k] = 1'b1; end
                end
                F: cur[k] = D;
                D: cur[k] = R;
                R: cur[k] = E;
                E: if (mem_r_en && mem_w_en) begin
                    merr[k] = 1'b1; cur[k] = H;
                end else begin
                    pn[k] = 0; pi[k] = 0; waits[k] = 0;
                    if (mem_r_en || mem_w_en) begin pl[k][pn[k]] = M; pn[k]++; end
                    if (reg_w_en) begin
                        pl[k][pn[k]] = WR; pn[k]++;
                        pl[k][pn[k]] = W;  pn[k]++;
                    end
                    pl[k][pn[k]] = P; pn[k]++;
                    cur[k] = next_stage(k);
                end
                M: if (mem_ready) cur[k] = next_stage(k);
                   else begin
                       mstl[k]++;
                       if (waits[k] == tmo - 1) begin merr[k] = 1'b1; cur[k] = H; end
                       else waits[k]++;
                   end
                WR, W: cur[k] = next_stage(k);
                P: begin
                    mret[k]++;
                    cur[k] = (halt_req || !run || ss[k]) ? H : F;
                    ss[k] = 1'b0;
                end
                default: cur[k] = H;
            endcase
        end
    endfunction

    task automatic check(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [9:0]  ev;
            logic [31:0] ec;
            ev[9] = (cur[k] == H);
            ev[8] = merr[k];
            for (int s = 1; s <= 8; s++) ev[s-1] = (cur[k] == s);
`ifdef CPU_SEQ_PERF_CNT_EN
            ec = {16'(mret[k]), 16'(mstl[k])};
`else
            ec = '0;
`endif
            checks++;
            assert ({hlt[k], er[k], stb[k]} === ev) else begin
                errs++;
                $error("FAIL %s dut%0d halted/err/strobes obs=%b exp=%b", tag, k, {hlt[k], er[k], stb[k]}, ev);
            end
            checks++;
            assert ({ret[k], stl[k]} === ec) else begin
                errs++;
                $error("FAIL %s dut%0d retired/stalls obs=%h exp=%h", tag, k, {ret[k], stl[k]}, ec);
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        m_step();
        #1;
        check(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_flags(input logic r, input logic w, input logic rw);
        mem_r_en = r; mem_w_en = w; reg_w_en = rw;
    endtask

    task automatic run_until(input int target, input string tag);
        int n = 0;
        while (cur[0] != target && n < 40) begin
            tick(tag);
            n++;
        end
        checks++;
        assert (cur[0] == target) else begin
            errs++;
            $error("FAIL %s wait obs_stage=%0d exp_stage=%0d", tag, cur[0], target);
        end
    endtask

    initial begin
        int lw_seq [9] = '{F, D, R, E, M, WR, W, P, F};
        logic [15:0] exp_ret1;
        #2;
        do_reset();

        // lw back-to-back with zero-wait memory: fixed strobe order cycles 1-9.
        set_flags(1, 0, 1); mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] oh;
            tick("lw");
            oh = 8'd1 << (lw_seq[i] - 1);
            checks++;
            assert (stb[0] === oh) else begin
                errs++;
                $error("FAIL lw_seq cycle%0d obs=%b exp=%b", i + 1, stb[0], oh);
            end
        end
`ifdef CPU_SEQ_PERF_CNT_EN
        exp_ret1 = 16'd1;
`else
        exp_ret1 = 16'd0;
`endif
        checks++;
        assert (ret[0] === exp_ret1) else begin
            errs++;
            $error("FAIL lw_retired obs=%0d exp=%0d", ret[0], exp_ret1);
        end

        // Single-step a branch twice.
        do_reset();
        run = 1'b0; set_flags(0, 0, 0);
        for (int n = 0; n < 2; n++) begin
            step = 1'b1;
            tick("step");
            step = 1'b0;
            for (int i = 0; i < 6; i++) tick("step");
        end

        // sw with three wait cycles, then ready.
        do_reset();
        set_flags(0, 1, 0); mem_ready = 1'b0; run = 1'b1;
        run_until(M, "sw_wait");
        tick("sw_wait"); tick("sw_wait"); tick("sw_wait");
        mem_ready = 1'b1; run = 1'b0;
        for (int i = 0; i < 4; i++) tick("sw_wait");

        // Memory never answers: both instances time out and stay halted.
        do_reset();
        set_flags(1, 0, 1); mem_ready = 1'b0; run = 1'b1;
        for (int i = 0; i < 20; i++) tick("timeout");

        // halt_req during EXEC of an ALU op does not truncate it.
        do_reset();
        set_flags(0, 0, 1); mem_ready = 1'b1; run = 1'b1;
        run_until(E, "halt_req");
        halt_req = 1'b1;
        for (int i = 0; i < 6; i++) tick("halt_req");
        halt_req = 1'b0;

        // Illegal flags abort right after EXEC.
        do_reset();
        set_flags(1, 1, 0); run = 1'b1;
        for (int i = 0; i < 8; i++) tick("illegal");

        // Asynchronous reset in the middle of MEM.
        do_reset();
        set_flags(1, 0, 0); mem_ready = 1'b0; run = 1'b1;
        run_until(M, "async");
        tick("async");
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised episodes; flags only change outside REGRD..PCUPD.
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                run       = ($urandom_range(0, 9) != 0);
                step      = ($urandom_range(0, 7) == 0);
                halt_req  = ($urandom_range(0, 15) == 0);
                mem_ready = ($urandom_range(0, 2) != 0);
                if (cur[0] <= D && cur[1] <= D) begin
                    int sel;
                    sel = $urandom_range(0, 15);
                    if (sel >= 15)     set_flags(1, 1, $urandom_range(0, 1) == 1);
                    else if (sel < 4)  set_flags(1, 0, 1);
                    else if (sel < 8)  set_flags(0, 1, 0);
                    else if (sel < 12) set_flags(0, 0, 1);
                    else               set_flags(0, 0, 0);
                end
                tick("random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
